// File: rtl/multistage_down_counter.sv
// Loadable down-counting interval timer built from a chain of narrow sub-counters.
// Optional macro MSDC_PRELOAD_EN allows a running count to be restarted by a new load.
module multistage_down_counter #(
    parameter int WIDTH   = 5,
    parameter int STAGE_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    localparam int NSTAGES = (WIDTH + STAGE_W - 1) / STAGE_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_reload;
    logic               r_done;

    logic [NSTAGES-1:0] w_zero;
    logic [NSTAGES-1:0] w_borrow;
    logic [WIDTH-1:0]   w_cnt_dec;
    logic               w_zero_all;
    logic               w_dec;
    logic               w_terminal;
    logic               w_load_ready;
    logic               w_load_acc;

    // A stage steps only when every stage below it is zero, so each borrow is a short AND chain.
    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int LO = k * STAGE_W;
        localparam int SW = (k == NSTAGES - 1) ? (WIDTH - LO) : STAGE_W;

        assign w_zero[k] = (r_cnt[LO +: SW] == {SW{1'b0}});

        if (k == 0) begin : g_first
            assign w_borrow[k] = w_dec;
        end else begin : g_upper
            assign w_borrow[k] = w_borrow[k-1] & w_zero[k-1];
        end

        assign w_cnt_dec[LO +: SW] = w_borrow[k] ? (r_cnt[LO +: SW] - SW'(1'b1))
                                                 : r_cnt[LO +: SW];
    end

    assign w_zero_all = &w_zero;
    assign w_dec      = (r_state == ST_RUN) & en & ~abort & ~w_zero_all;
    assign w_terminal = (r_state == ST_RUN) & en & ~abort &  w_zero_all;

`ifdef MSDC_PRELOAD_EN
    assign w_load_ready = ~abort;
`else
    assign w_load_ready = (r_state == ST_IDLE) & ~abort;
`endif

    assign w_load_acc = load_valid & w_load_ready;

    assign load_ready = w_load_ready;
    assign cnt        = r_cnt;
    assign busy       = (r_state == ST_RUN);
    assign done       = r_done;

    // Control FSM: load, count, terminal reload/stop and abort handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {WIDTH{1'b0}};
            r_reload <= {WIDTH{1'b0}};
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load_acc) begin
                        r_cnt    <= load_value;
                        r_reload <= load_value;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_cnt   <= {WIDTH{1'b0}};
                        r_state <= ST_IDLE;
                    end else if (w_terminal) begin
                        r_done <= 1'b1;
                        // A coincident restart load beats both reload and stop.
                        if (w_load_acc) begin
                            r_cnt    <= load_value;
                            r_reload <= load_value;
                        end else if (auto_reload) begin
                            r_cnt    <= r_reload;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end else if (w_load_acc) begin
                        r_cnt    <= load_value;
                        r_reload <= load_value;
                    end else if (w_dec) begin
                        r_cnt    <= w_cnt_dec;
                    end else begin
                        r_cnt    <= r_cnt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: doc/multistage_down_counter.md
Name: multistage_down_counter

Overview:
- Loadable, multistage down-counting timer, built as a chain of narrow sub-counters.
- It is the count-down counterpart of the team's multistage up-counter. Each stage decrements only when all lower stages are zero, so the carry/borrow path stays short.
- Used as an interval or timeout timer: software or an FSM loads a value, the block counts down to zero and emits a one-cycle done pulse.
- Supports one-shot or auto-reload operation.

Parameters:
- WIDTH, 5, total counter width in bits.
- STAGE_W, 2, bits per stage. NSTAGES = ceil(WIDTH/STAGE_W); the top stage takes the remaining WIDTH - (NSTAGES-1)*STAGE_W bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; no decrement while low.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load.
- load_value  input  WIDTH  start and reload value.
- auto_reload  input  1  sampled at the terminal edge; 1 = reload, 0 = stop.
- abort  input  1  cancel the current count.
- cnt  output  WIDTH  current count, the concatenation of the stages with stage 0 in the LSBs.
- busy  output  1  high in the RUN state.
- done  output  1  one-cycle terminal pulse.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Assertion immediately forces:
  - cnt=0, the reload register to 0, state=IDLE, done=0, busy=0.
  - Reset mid-count discards the count silently; done does not pulse.
- States: IDLE and RUN. busy = (state==RUN).
- Handshake:
  - load_ready = (state==IDLE) & ~abort. After reset load_ready=1.
  - A load is accepted on an edge where load_valid & load_ready. On that edge: cnt<=load_value, reload register<=load_value, state<=RUN.
  - load_value is don't-care when no load is accepted.
- Stage borrow:
  - z_k = stage k is all-zero. zero_all = AND of all z_k.
  - dec = (state==RUN) & en & ~abort & ~zero_all.
  - Stage 0 decrements when dec is true.
  - Stage k>0 decrements when dec & z_0 & ... & z_(k-1). It wraps from 0 to all-ones.
  - The overall result is an exact binary decrement, e.g. 10000 -> 01111.
- Terminal edge (state==RUN & en & ~abort & zero_all):
  - done<=1 for exactly one cycle.
  - If auto_reload=1: cnt<=reload register and the state stays RUN.
  - If auto_reload=0: the state goes to IDLE and cnt stays 0.
- Latency and period:
  - After loading N with en held high, cnt reaches 0 N edges after the load edge.
  - done is high during the cycle following edge N+1.
  - The auto-reload period is N+1 cycles. N=0 gives done after edge 1, with period 1: done continuously high.
- en low: everything holds, including the terminal event. Handshake acceptance is independent of en.
- abort, sampled on the edge:
  - In RUN: cnt<=0, state<=IDLE, no done.
  - abort wins over a simultaneous terminal edge (no done) and over load_valid (load not accepted).
  - In IDLE: no effect other than forcing load_ready low.
- done is registered and never asserted in IDLE except in the cycle following a terminal edge.

Optional Feature:
- Macro: MSDC_PRELOAD_EN.
- Defined:
  - load_ready = ~abort in both states.
  - A load accepted in RUN restarts the count: cnt and the reload register take load_value, and the state stays RUN.
  - If this coincides with a terminal edge, done still pulses and load_value overrides the auto_reload/stop outcome (state RUN).
- Undefined: load_ready=0 throughout RUN, and loads in RUN are ignored.

Test Plan:
- Reset check: assert reset mid-count at cnt=9 -> cnt=0, busy=0, done=0, load_ready=1 immediately, with no clock edge needed.
- One-shot count: load 5, auto_reload=0, en=1 -> cnt 5,4,3,2,1,0; done high for exactly one cycle after edge 6; then busy=0 and load_ready=1.
- Auto-reload across stages: load 31, auto_reload=1 -> decrements are exact at 16->15 and 4->3; done pulses every 32 cycles; cnt returns to 31 after each pulse.
- Enable gating: drop en for 3 cycles at cnt=12 -> cnt holds 12 and no done; when en resumes, the count continues to 11.
- Abort cases: abort at cnt=7 -> next edge cnt=0, IDLE, no done. abort on the terminal edge -> no done. abort together with load_valid in IDLE -> not accepted.
- Load 0 and preload: load 0 -> done after edge 1. With MSDC_PRELOAD_EN, load 20 while running at cnt=3 -> cnt=20, busy stays 1. Without the macro, load_ready=0 and the load is ignored.
